// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, entry layout and constants for the fetch unit
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory handshake plus decode-side instruction and branch signals
interface fetch_unit_if;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic inst_valid;
  logic inst_ready;
  logic pcsrc;
  logic [31:0] branch_target;
  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid,
    input imem_ack, imem_rdata, inst_ready, pcsrc, branch_target
  );
  modport slave (
    input imem_req, imem_addr, inst, inst_pc, inst_valid,
    output imem_ack, imem_rdata, inst_ready, pcsrc, branch_target
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: {pc, inst} queue toward decode with a registered head that holds when empty
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  entry_t din,
  output entry_t head,
  output logic valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr, rd_n;
  logic [CW-1:0] left, cnt_n;
  logic do_push, do_pop;
  always_comb begin
    do_pop = pop & valid & ~flush;
    do_push = push & ~flush;
    rd_n = rd + AW'(do_pop);
    left = count - CW'(do_pop);
    cnt_n = flush ? '0 : left + CW'(do_push);
  end
  // head is reloaded from the bypassed push when the queue would otherwise be empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      valid <= 1'b0;
      head <= {32'h0, NOP_INST};
    end else begin
      rd <= flush ? '0 : rd_n;
      wr <= flush ? '0 : wr + AW'(do_push);
      count <= cnt_n;
      valid <= cnt_n != '0;
      if (cnt_n != '0) head <= left == '0 ? din : mem[rd_n];
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, single-outstanding fetch FSM and redirect handling feeding a small FIFO
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);
  state_t state, state_n;
  logic [31:0] pc, pc_n, tgt, tgt_n, target;
  logic [CW-1:0] count, left;
  logic push, pop, valid;
  entry_t din, head;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      tgt <= RESET_PC;
    end else begin
      state <= state_n;
      pc <= pc_n;
      tgt <= tgt_n;
    end
  // a new request is committed only while the FIFO can still absorb its word
  always_comb begin
    target = bus.branch_target & ~32'h3;
    pop = valid & bus.inst_ready;
    left = count - CW'(pop);
    state_n = state;
    pc_n = pc;
    tgt_n = tgt;
    push = 1'b0;
    case (state)
      IDLE:
        if (bus.pcsrc) begin
          pc_n = target;
          state_n = FETCH;
        end else if (left < CW'(DEPTH)) state_n = FETCH;
      FETCH:
        if (bus.imem_ack && bus.pcsrc) pc_n = target;
        else if (bus.imem_ack) begin
          push = 1'b1;
          pc_n = pc + PC_STEP;
          state_n = left + CW'(1) < CW'(DEPTH) ? FETCH : IDLE;
        end else if (bus.pcsrc) begin
          tgt_n = target;
          state_n = DISCARD;
        end
      DISCARD:
        if (bus.imem_ack) begin
          pc_n = bus.pcsrc ? target : tgt;
          state_n = FETCH;
        end else if (bus.pcsrc) tgt_n = target;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    din.pc = pc;
    din.inst = bus.imem_rdata;
    bus.imem_req = state != IDLE;
    bus.imem_addr = pc;
    bus.inst = head.inst;
    bus.inst_pc = head.pc;
    bus.inst_valid = valid;
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(bus.pcsrc),
    .din(din),
    .head(head),
    .valid(valid),
    .count(count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios checked against a queue-based fetch model plus literal expectations
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_w = 1'b0;
  logic ack_en = 1'b0;
  logic ack_w_en = 1'b0;
  int checks = 0;
  int failures = 0;
  int n;
  fetch_unit_if bus();
  fetch_unit_if wb();
  fetch_unit u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (.clk(clk), .rst_n(rst_w), .bus(wb));
  always #5 clk = ~clk;
  assign bus.imem_ack = bus.imem_req & ack_en;
  assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;
  assign wb.imem_ack = wb.imem_req & ack_w_en;
  assign wb.imem_rdata = wb.imem_addr ^ 32'hA5A5_0000;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic cyc(input int k = 1);
    repeat (k) @(negedge clk);
  endtask
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t q[$];
  logic [31:0] next_addr = 32'h0;
  logic [31:0] held = 32'h0;
  logic [31:0] prev_addr = 32'h0;
  logic pending = 1'b0;
  logic prev_req = 1'b0;
  logic prev_ack = 1'b0;
  logic fire;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.delete();
      next_addr = 32'h0;
      pending = 1'b0;
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      fire = bus.imem_req & bus.imem_ack;
      prev_req = bus.imem_req;
      prev_ack = bus.imem_ack;
      prev_addr = bus.imem_addr;
      if (bus.pcsrc) q.delete();
      else begin
        if (q.size() > 0 && bus.inst_ready) void'(q.pop_front());
        if (fire && !pending) q.push_back('{next_addr, next_addr ^ 32'hA5A5_0000});
      end
      if (fire) begin
        next_addr = bus.pcsrc ? (bus.branch_target & ~32'h3) : pending ? held : next_addr + 32'd4;
        pending = 1'b0;
      end else if (bus.pcsrc && bus.imem_req) begin
        pending = 1'b1;
        held = bus.branch_target & ~32'h3;
      end else if (bus.pcsrc) next_addr = bus.branch_target & ~32'h3;
    end
  always @(negedge clk)
    if (rst_n) begin
      chk("m_valid", {31'h0, bus.inst_valid}, {31'h0, q.size() > 0});
      if (q.size() > 0) begin
        chk("m_inst", bus.inst, q[0].inst);
        chk("m_inst_pc", bus.inst_pc, q[0].pc);
      end
      if (bus.imem_req && !pending) chk("m_addr", bus.imem_addr, next_addr);
      if (prev_req && !prev_ack) begin
        chk("m_req_hold", {31'h0, bus.imem_req}, 32'h1);
        chk("m_addr_hold", bus.imem_addr, prev_addr);
      end
      chk("m_credit", {31'h0, (q.size() + int'(bus.imem_req)) <= 2}, 32'h1);
    end
  task automatic do_reset();
    rst_n = 1'b0;
    ack_en = 1'b0;
    bus.inst_ready = 1'b0;
    bus.pcsrc = 1'b0;
    bus.branch_target = 32'h0;
    cyc(2);
    chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", {31'h0, bus.inst_valid}, 32'h0);
    chk("rst_inst", bus.inst, 32'h0000_0013);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    rst_n = 1'b1;
  endtask
  initial begin
    wb.inst_ready = 1'b0;
    wb.pcsrc = 1'b0;
    wb.branch_target = 32'h0;
    do_reset();
    ack_en = 1'b1;
    bus.inst_ready = 1'b1;
    cyc();
    chk("s_req0", {31'h0, bus.imem_req}, 32'h1);
    chk("s_addr0", bus.imem_addr, 32'h0);
    cyc();
    chk("s_addr1", bus.imem_addr, 32'h4);
    chk("s_inst0", bus.inst, 32'hA5A5_0000);
    chk("s_pc0", bus.inst_pc, 32'h0);
    cyc();
    chk("s_addr2", bus.imem_addr, 32'h8);
    chk("s_inst1", bus.inst, 32'hA5A5_0004);
    chk("s_pc1", bus.inst_pc, 32'h4);
    n = 0;
    repeat (10) begin
      cyc();
      n += int'(bus.imem_ack);
    end
    chk("s_rate", n, 10);
    do_reset();
    ack_en = 1'b1;
    n = 0;
    repeat (6) begin
      cyc();
      n += int'(bus.imem_ack);
    end
    chk("bp_acks", n, 2);
    chk("bp_idle", {31'h0, bus.imem_req}, 32'h0);
    chk("bp_pc", bus.inst_pc, 32'h0);
    bus.inst_ready = 1'b1;
    cyc();
    bus.inst_ready = 1'b0;
    chk("bp_req", {31'h0, bus.imem_req}, 32'h1);
    chk("bp_addr", bus.imem_addr, 32'h8);
    chk("bp_pc1", bus.inst_pc, 32'h4);
    cyc();
    chk("ri_idle", {31'h0, bus.imem_req}, 32'h0);
    chk("ri_full", {31'h0, bus.inst_valid}, 32'h1);
    bus.pcsrc = 1'b1;
    bus.branch_target = 32'h0000_0103;
    ack_en = 1'b0;
    cyc();
    bus.pcsrc = 1'b0;
    chk("ri_valid", {31'h0, bus.inst_valid}, 32'h0);
    chk("ri_req", {31'h0, bus.imem_req}, 32'h1);
    chk("ri_addr", bus.imem_addr, 32'h0000_0100);
    do_reset();
    ack_en = 1'b1;
    bus.inst_ready = 1'b1;
    cyc(3);
    ack_en = 1'b0;
    chk("mr_addr8", bus.imem_addr, 32'h8);
    cyc();
    bus.pcsrc = 1'b1;
    bus.branch_target = 32'h40;
    cyc();
    bus.branch_target = 32'h80;
    chk("mr_stale", bus.imem_addr, 32'h8);
    chk("mr_flush", {31'h0, bus.inst_valid}, 32'h0);
    cyc();
    bus.pcsrc = 1'b0;
    ack_en = 1'b1;
    chk("mr_hold", bus.imem_addr, 32'h8);
    cyc();
    chk("mr_addr", bus.imem_addr, 32'h80);
    chk("mr_empty", {31'h0, bus.inst_valid}, 32'h0);
    cyc();
    chk("mr_valid", {31'h0, bus.inst_valid}, 32'h1);
    chk("mr_pc", bus.inst_pc, 32'h80);
    chk("mr_inst", bus.inst, 32'hA5A5_0080);
    bus.pcsrc = 1'b1;
    bus.branch_target = 32'h200;
    cyc();
    bus.pcsrc = 1'b0;
    chk("arp_valid", {31'h0, bus.inst_valid}, 32'h0);
    chk("arp_req", {31'h0, bus.imem_req}, 32'h1);
    chk("arp_addr", bus.imem_addr, 32'h200);
    cyc();
    chk("arp_pc", bus.inst_pc, 32'h200);
    cyc(4);
    ack_en = 1'b0;
    wb.inst_ready = 1'b1;
    ack_w_en = 1'b1;
    chk("w_rst_req", {31'h0, wb.imem_req}, 32'h0);
    chk("w_rst_addr", wb.imem_addr, 32'hFFFF_FFF8);
    rst_w = 1'b1;
    cyc();
    chk("w_a0", wb.imem_addr, 32'hFFFF_FFF8);
    cyc();
    chk("w_a1", wb.imem_addr, 32'hFFFF_FFFC);
    chk("w_pc0", wb.inst_pc, 32'hFFFF_FFF8);
    cyc();
    chk("w_a2", wb.imem_addr, 32'h0);
    chk("w_pc1", wb.inst_pc, 32'hFFFF_FFFC);
    cyc();
    ack_w_en = 1'b0;
    chk("w_pend", {31'h0, wb.imem_req}, 32'h1);
    chk("w_a3", wb.imem_addr, 32'h4);
    #2 rst_w = 1'b0;
    #1;
    chk("w_async_req", {31'h0, wb.imem_req}, 32'h0);
    chk("w_async_valid", {31'h0, wb.inst_valid}, 32'h0);
    chk("w_async_addr", wb.imem_addr, 32'hFFFF_FFF8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
